// File: rtl/conv_sequencer.sv
// Frame sequencer for the streaming KERN_DIM x KERN_DIM convolver: loads weights,
// admits a raster-order image and flags cycles where the datapath window is complete.
module conv_sequencer #(
    parameter int KERN_DIM = 3,
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28,
    parameter int CNT_BW   = 5,
    parameter int WADDR_BW = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                reload_w,
    input  logic                w_valid,
    output logic                w_ready,
    output logic                weight_we,
    output logic [WADDR_BW-1:0] weight_addr,
    input  logic                pix_valid,
    output logic                pix_ready,
    output logic                shift_en,
    output logic [CNT_BW-1:0]   row,
    output logic [CNT_BW-1:0]   col,
    output logic                out_valid,
    output logic                busy,
    output logic                done
);

    localparam logic [WADDR_BW-1:0] LAST_W   = WADDR_BW'(KERN_DIM * KERN_DIM - 1);
    localparam logic [CNT_BW-1:0]   LAST_COL = CNT_BW'(WIDTH - 1);
    localparam logic [CNT_BW-1:0]   LAST_ROW = CNT_BW'(HEIGHT - 1);
    localparam logic [CNT_BW-1:0]   WIN_MIN  = CNT_BW'(KERN_DIM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [WADDR_BW-1:0] waddr_reg, waddr_next;
    logic [CNT_BW-1:0]   row_reg, row_next;
    logic [CNT_BW-1:0]   col_reg, col_next;
    logic                out_valid_reg, out_valid_next;
    logic                done_reg, done_next;

    logic last_weight;
    logic last_col;
    logic last_pixel;
    logic in_window;

    assign w_ready     = (state_reg == LOAD_W);
    assign pix_ready   = (state_reg == STREAM);
    assign weight_we   = w_valid & w_ready;
    assign shift_en    = pix_valid & pix_ready;
    assign busy        = (state_reg != IDLE);

    assign last_weight = weight_we && (waddr_reg == LAST_W);
    assign last_col    = (col_reg == LAST_COL);
    assign last_pixel  = shift_en && last_col && (row_reg == LAST_ROW);
    assign in_window   = (row_reg >= WIN_MIN) && (col_reg >= WIN_MIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            waddr_reg     <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            waddr_reg     <= waddr_next;
            row_reg       <= row_next;
            col_reg       <= col_next;
            out_valid_reg <= out_valid_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        waddr_next     = waddr_reg;
        row_next       = row_reg;
        col_next       = col_reg;
        out_valid_next = 1'b0;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                waddr_next = '0;
                row_next   = '0;
                col_next   = '0;
                if (start) begin
                    state_next = reload_w ? LOAD_W : STREAM;
                end
            end
            LOAD_W: begin
                if (weight_we) begin
                    if (last_weight) begin
                        waddr_next = '0;
                        state_next = STREAM;
                    end else begin
                        waddr_next = waddr_reg + 1'b1;
                    end
                end
            end
            STREAM: begin
                if (shift_en) begin
                    // The datapath output register delays the window by one cycle.
                    out_valid_next = in_window;
                    if (last_col) begin
                        col_next = '0;
                        row_next = (row_reg == LAST_ROW) ? '0 : row_reg + 1'b1;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                    if (last_pixel) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign weight_addr = waddr_reg;
    assign row         = row_reg;
    assign col         = col_reg;
    assign out_valid   = out_valid_reg;
    assign done        = done_reg;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: reset, weight load, full frames, backpressure and abort.
module tb_conv_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       reload_w;
    logic       w_valid;
    logic       w_ready;
    logic       weight_we;
    logic [3:0] weight_addr;
    logic       pix_valid;
    logic       pix_ready;
    logic       shift_en;
    logic [4:0] row;
    logic [4:0] col;
    logic       out_valid;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    conv_sequencer #(
        .KERN_DIM(3), .WIDTH(28), .HEIGHT(28), .CNT_BW(5), .WADDR_BW(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .reload_w(reload_w),
        .w_valid(w_valid), .w_ready(w_ready), .weight_we(weight_we),
        .weight_addr(weight_addr), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .shift_en(shift_en), .row(row), .col(col), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, done, w_ready, pix_ready, weight_we, shift_en} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000000",
                     {busy, out_valid, done, w_ready, pix_ready, weight_we, shift_en});
        end
        checks++;
        if (row !== 5'd0 || col !== 5'd0 || weight_addr !== 4'd0) begin
            failures++;
            $display("FAIL reset_counters got row=%0d col=%0d waddr=%0d want 0/0/0",
                     row, col, weight_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("test_reset complete");
    endtask

    task automatic start_frame(input bit reload);
        @(negedge clk);
        start     = 1'b1;
        reload_w  = reload;
        w_valid   = 1'b0;
        pix_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_idle busy got=%b want=0", busy);
        end
    endtask

    task automatic load_weights();
        int  exp_addr = 0;
        int  acc = 0;
        int  cyc = 0;
        bit  wv;
        while (acc < 9 && cyc < 100) begin
            @(negedge clk);
            start     = 1'b0;
            reload_w  = 1'b0;
            wv        = cyc[0];
            w_valid   = wv;
            pix_valid = 1'b1;
            #1;
            checks++;
            if (weight_addr !== 4'(exp_addr) || weight_we !== wv || w_ready !== 1'b1
                || shift_en !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL load_w cyc=%0d got addr=%0d we=%b rdy=%b sh=%b want addr=%0d we=%b rdy=1 sh=0",
                         cyc, weight_addr, weight_we, w_ready, shift_en, exp_addr, wv);
            end
            if (wv) begin
                acc++;
                exp_addr = (exp_addr == 8) ? 0 : exp_addr + 1;
            end
            cyc++;
        end
        checks++;
        if (acc !== 9) begin
            failures++;
            $display("FAIL load_w_count got=%0d want=9", acc);
        end
        $display("load_weights accepted=%0d", acc);
    endtask

    task automatic stream_frame(input string name, input int n_pix, input bit gaps, input bit poke);
        int r = 0, c = 0, acc = 0, cyc = 0, pulses = 0, dones = 0;
        bit pv;
        bit exp_ov = 1'b0;
        bit exp_done = 1'b0;
        while (acc < n_pix && cyc < 5000) begin
            @(negedge clk);
            start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            reload_w  = start;
            w_valid   = 1'b1;
            pv        = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_valid = pv;
            #1;
            checks++;
            if (out_valid !== exp_ov || done !== exp_done) begin
                failures++;
                $display("FAIL %s out px=%0d got ov=%b done=%b want ov=%b done=%b",
                         name, acc, out_valid, done, exp_ov, exp_done);
            end
            checks++;
            if (row !== 5'(r) || col !== 5'(c)) begin
                failures++;
                $display("FAIL %s pos got=(%0d,%0d) want=(%0d,%0d)", name, row, col, r, c);
            end
            checks++;
            if (pix_ready !== 1'b1 || shift_en !== pv || weight_we !== 1'b0
                || weight_addr !== 4'd0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL %s ctrl got rdy=%b sh=%b we=%b wa=%0d busy=%b want 1 %b 0 0 1",
                         name, pix_ready, shift_en, weight_we, weight_addr, busy, pv);
            end
            pulses += int'(out_valid);
            dones  += int'(done);
            exp_ov   = pv && r >= 2 && c >= 2;
            exp_done = pv && r == 27 && c == 27;
            if (pv) begin
                acc++;
                if (c == 27) begin
                    c = 0;
                    r = (r == 27) ? 0 : r + 1;
                end else begin
                    c++;
                end
            end
            cyc++;
        end
        checks++;
        if (acc !== n_pix) begin
            failures++;
            $display("FAIL %s timeout accepted=%0d want=%0d", name, acc, n_pix);
        end
        if (n_pix == 784) begin
            @(negedge clk);
            pix_valid = 1'b0;
            w_valid   = 1'b0;
            start     = poke;
            reload_w  = poke;
            #1;
            checks++;
            if (out_valid !== 1'b1 || done !== 1'b1 || busy !== 1'b1 || pix_ready !== 1'b0
                || row !== 5'd0 || col !== 5'd0) begin
                failures++;
                $display("FAIL %s done_cycle got ov=%b done=%b busy=%b rdy=%b pos=(%0d,%0d) want 1 1 1 0 (0,0)",
                         name, out_valid, done, busy, pix_ready, row, col);
            end
            pulses += int'(out_valid);
            dones  += int'(done);
            checks++;
            if (pulses !== 676 || dones !== 1) begin
                failures++;
                $display("FAIL %s totals got pulses=%0d dones=%0d want 676/1", name, pulses, dones);
            end
            @(negedge clk);
            start    = 1'b0;
            reload_w = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s after_done got busy=%b done=%b ov=%b want 0 0 0",
                         name, busy, done, out_valid);
            end
        end
        $display("%s pixels=%0d cycles=%0d pulses=%0d", name, acc, cyc, pulses);
    endtask

    task automatic test_weight_load();
        start_frame(1'b1);
        load_weights();
    endtask

    task automatic test_full_frame();
        stream_frame("full_frame", 784, 1'b0, 1'b0);
    endtask

    task automatic test_reuse();
        start_frame(1'b0);
        stream_frame("reuse", 784, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        start_frame(1'b0);
        stream_frame("backpressure", 784, 1'b1, 1'b1);
    endtask

    task automatic test_abort();
        start_frame(1'b0);
        stream_frame("abort_partial", 300, 1'b0, 1'b0);
        pix_valid = 1'b0;
        w_valid   = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || row !== 5'd0 || col !== 5'd0 || done !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort got busy=%b pos=(%0d,%0d) done=%b ov=%b want 0 (0,0) 0 0",
                     busy, row, col, done, out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold got done=%b busy=%b want 0 0", done, busy);
        end
        reset = 1'b1;
        start_frame(1'b0);
        stream_frame("after_abort", 784, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        reload_w  = 1'b0;
        w_valid   = 1'b0;
        pix_valid = 1'b0;
        test_reset();
        test_weight_load();
        test_full_frame();
        test_reuse();
        test_backpressure();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
Top-level sequencer for the KERN_DIM x KERN_DIM streaming convolver.
- Loads the kernel weights into the weight register file.
- Admits a raster-order WIDTH x HEIGHT image one pixel per handshake.
- Drives the datapath shift enable.
- Flags the cycles on which the datapath window holds a complete, valid neighbourhood.
- Sits between the input stream source and the convolver datapath (line buffers, window registers, MAC tree).

Parameters:
KERN_DIM, 3, kernel edge length
WIDTH, 28, image columns
HEIGHT, 28, image rows
CNT_BW, 5, row/col counter width; must satisfy 2^CNT_BW >= max(WIDTH,HEIGHT)
WADDR_BW, 4, weight address width; must satisfy 2^WADDR_BW >= KERN_DIM*KERN_DIM

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a frame; sampled only in IDLE
reload_w  input  1  sampled with start: 1 = load weights first, 0 = reuse stored weights
w_valid  input  1  weight source has a weight on the bus
w_ready  output  1  sequencer accepts a weight (combinational: state==LOAD_W)
weight_we  output  1  weight write strobe = w_valid & w_ready
weight_addr  output  WADDR_BW  write address of the current weight, 0..KERN_DIM^2-1
pix_valid  input  1  pixel source has a pixel on the bus
pix_ready  output  1  sequencer accepts a pixel (combinational: state==STREAM)
shift_en  output  1  datapath shift strobe = pix_valid & pix_ready
row  output  CNT_BW  row of the next pixel to be accepted (registered)
col  output  CNT_BW  column of the next pixel to be accepted (registered)
out_valid  output  1  datapath window output valid this cycle (registered)
busy  output  1  state != IDLE
done  output  1  one-cycle frame-complete pulse (registered)

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - weight_addr=0, row=0, col=0.
  - out_valid=0, done=0.
  - All combinational outputs are low as a consequence.
- States: IDLE, LOAD_W, STREAM, DONE.
- IDLE:
  - start=1 with reload_w=1 -> LOAD_W.
  - start=1 with reload_w=0 -> STREAM.
  - row, col and weight_addr are cleared to 0 on leaving IDLE.
- LOAD_W:
  - Each accepted weight (weight_we=1) increments weight_addr.
  - On the weight accepted at address KERN_DIM^2-1: weight_addr returns to 0 and the state goes to STREAM next cycle.
  - w_valid gaps hold weight_addr.
- STREAM:
  - Each accepted pixel advances col.
  - At col==WIDTH-1, col wraps to 0 and row increments.
  - pix_valid gaps hold all counters; out_valid is 0 during gaps.
- out_valid:
  - Asserts 1 cycle after a pixel is accepted at (row>=KERN_DIM-1 && col>=KERN_DIM-1); otherwise 0.
  - This matches the one-cycle registered datapath output.
  - Per frame: exactly (WIDTH-KERN_DIM+1)*(HEIGHT-KERN_DIM+1) pulses (676 at defaults).
- Last pixel accepted at (HEIGHT-1, WIDTH-1):
  - row and col wrap to 0.
  - State goes to DONE next cycle.
  - In DONE: done=1 and out_valid=1 (final window) in the same cycle.
  - DONE -> IDLE unconditionally after 1 cycle.
- start is ignored in every state except IDLE, including DONE. An earliest new frame starts from IDLE on the cycle after DONE.
- Weights are never written outside LOAD_W. w_valid in any other state has no effect.
- Reset mid-operation aborts immediately: state returns to IDLE and no done pulse is produced. Partially loaded weights are left to the datapath and are not restored.
- Counters never exceed their terminal values. No state other than the four listed is reachable; any illegal encoding transitions to IDLE.

Test Plan:
1. Assert reset mid-clock with all inputs at 0 -> immediately state=IDLE, busy=0, row=col=0, weight_addr=0, out_valid=done=0, w_ready=pix_ready=0.
2. Weight load: start=1, reload_w=1; 9 weights with w_valid low on every other cycle -> weight_we pulses 9 times at addresses 0..8; pix_ready rises the cycle after the 9th weight.
3. Full frame, no gaps: pix_valid held 1 for 784 cycles ->
   - first out_valid 1 cycle after pixel index 58 (row 2, col 2);
   - no out_valid after pixels at col 0/1;
   - 676 pulses in total;
   - done=1 one cycle after pixel 783, coincident with the last out_valid;
   - busy=0 on the following cycle.
4. Reuse weights: start=1, reload_w=0 -> STREAM entered the next cycle; weight_we stays 0 throughout; 676 out_valid pulses.
5. Backpressure: random pix_valid (~50%) -> row/col hold on gaps; out_valid count is still 676; done is still a single pulse; start pulses while busy are ignored.
6. Reset asserted after 300 pixels -> state returns to IDLE with no done pulse; a new start with reload_w=0 runs a clean frame from row 0, col 0.
